parking_entry_frontend: RTL and testbench

Input-conditioning stage directly upstream of the parking gate controller. Synchronises and debounces the raw front/back vehicle sensors. Captures a two-digit password from a 2-bit digit switch plus an enter key. Drives the gate controller's Front_Sensor, Back_Sensor, pass_1 and pass_2 inputs with clean, stable levels.

---
 rtl/parking_entry_frontend.sv | 225 ++++++++++++++++++++++
 tb/tb_parking_entry_frontend.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/parking_entry_frontend.sv
// parking_entry_frontend: input conditioning ahead of the parking gate controller.
// Synchronises and debounces the front/back vehicle sensors, synchronises the
// enter/clear keys, and captures a two-digit password that is presented to the
// gate controller only once both digits are in.
// Optional build macro: ENTRY_TIMEOUT_EN adds an idle timeout that discards a
// half-entered password after ENTRY_TIMEOUT cycles.

// Two-flop synchroniser, one lane per bit.
module parking_entry_sync2 #(
    parameter int W = 1
) (
    input  logic         clock_in,
    input  logic         rst_in,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta;

    // First flop absorbs metastability, second provides the clean level.
    always_ff @(posedge clock_in or negedge rst_in) begin
        if (!rst_in) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// Debouncer for one synchronised sensor lane.
module parking_entry_debounce #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 8
) (
    input  logic clock_in,
    input  logic rst_in,
    input  logic sync_in,
    output logic deb_out
);
    logic [CNT_W-1:0] cnt;

    // Count consecutive disagreeing samples; flip the output after DEB_CYCLES of them.
    always_ff @(posedge clock_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt     <= '0;
            deb_out <= 1'b0;
        end else if (sync_in == deb_out) begin
            cnt <= '0;
        end else if (cnt == CNT_W'(DEB_CYCLES - 1)) begin
            cnt     <= '0;
            deb_out <= ~deb_out;
        end else begin
            cnt <= cnt + CNT_W'(1);
        end
    end
endmodule

module parking_entry_frontend #(
    parameter int DEB_CYCLES    = 4,
    parameter int CNT_W         = 8,
    parameter int ENTRY_TIMEOUT = 64
) (
    input  logic       clock_in,
    input  logic       rst_in,
    input  logic       front_raw,
    input  logic       back_raw,
    input  logic       key_enter,
    input  logic       clear_in,
    input  logic [1:0] digit_in,
    output logic       Front_Sensor,
    output logic       Back_Sensor,
    output logic [1:0] pass_1,
    output logic [1:0] pass_2,
    output logic       pass_valid,
    output logic [1:0] digit_cnt
);
    localparam int NUM_LANES = 2;   // lane 0 = front sensor, lane 1 = back sensor

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Everything the gate controller sees, registered together.
    typedef struct packed {
        logic       valid;
        logic [1:0] p1;
        logic [1:0] p2;
        logic [1:0] cnt;
    } pass_t;

    logic [3:0]           raw_bus;
    logic [3:0]           syn_bus;
    logic [NUM_LANES-1:0] deb;
    logic                 key_syn;
    logic                 clr_syn;
    logic                 key_d;
    logic                 back_d;
    logic                 key_evt;
    logic                 back_evt;
    logic                 clr_evt;
    logic                 tmo_hit;
    state_t               state;
    logic [1:0]           d1;
    pass_t                pass_q;

    assign raw_bus = {clear_in, key_enter, back_raw, front_raw};

    parking_entry_sync2 #(.W(4)) u_sync (
        .clock_in (clock_in),
        .rst_in   (rst_in),
        .d        (raw_bus),
        .q        (syn_bus)
    );

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_deb
            parking_entry_debounce #(
                .DEB_CYCLES (DEB_CYCLES),
                .CNT_W      (CNT_W)
            ) u_deb (
                .clock_in (clock_in),
                .rst_in   (rst_in),
                .sync_in  (syn_bus[g]),
                .deb_out  (deb[g])
            );
        end
    endgenerate

    assign key_syn      = syn_bus[2];
    assign clr_syn      = syn_bus[3];
    assign Front_Sensor = deb[0];
    assign Back_Sensor  = deb[1];

    // Previous-cycle copies for rising-edge detection of key and back sensor.
    always_ff @(posedge clock_in or negedge rst_in) begin
        if (!rst_in) begin
            key_d  <= 1'b0;
            back_d <= 1'b0;
        end else begin
            key_d  <= key_syn;
            back_d <= deb[1];
        end
    end

    assign key_evt  = key_syn & ~key_d;
    assign back_evt = deb[1] & ~back_d;
    // A vehicle passing the back sensor also wipes any password in progress.
    assign clr_evt  = clr_syn | back_evt;

`ifdef ENTRY_TIMEOUT_EN
    logic [CNT_W-1:0] tmo_cnt;

    // Idle counter: held at zero outside ONE and restarted by every key press.
    always_ff @(posedge clock_in or negedge rst_in) begin
        if (!rst_in) begin
            tmo_cnt <= '0;
        end else if (state != ONE || key_evt) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
        end
    end

    assign tmo_hit = (state == ONE) && (tmo_cnt == CNT_W'(ENTRY_TIMEOUT - 1));
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (ENTRY_TIMEOUT > 0);
    assign tmo_hit            = 1'b0;
`endif

    // Entry FSM; outputs are updated alongside the state so they stay registered.
    // The second digit lives only in pass_q.p2, which is exactly what d2 would be.
    always_ff @(posedge clock_in or negedge rst_in) begin
        if (!rst_in) begin
            state  <= EMPTY;
            d1     <= 2'b00;
            pass_q <= '0;
        end else if (clr_evt) begin
            state  <= EMPTY;
            d1     <= 2'b00;
            pass_q <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (key_evt) begin
                        state      <= ONE;
                        d1         <= digit_in;
                        pass_q.cnt <= 2'd1;
                    end
                end
                ONE: begin
                    if (key_evt) begin
                        state        <= FULL;
                        pass_q.valid <= 1'b1;
                        pass_q.p1    <= d1;
                        pass_q.p2    <= digit_in;
                        pass_q.cnt   <= 2'd2;
                    end else if (tmo_hit) begin
                        state      <= EMPTY;
                        d1         <= 2'b00;
                        pass_q.cnt <= 2'd0;
                    end
                end
                FULL: begin
                    // Complete password is held until cleared.
                end
                default: begin
                    state  <= EMPTY;
                    d1     <= 2'b00;
                    pass_q <= '0;
                end
            endcase
        end
    end

    assign pass_valid = pass_q.valid;
    assign pass_1     = pass_q.p1;
    assign pass_2     = pass_q.p2;
    assign digit_cnt  = pass_q.cnt;
endmodule

// File: tb/tb_parking_entry_frontend.sv
// Bench for parking_entry_frontend: directed scenarios plus a random run that
// is checked every cycle against a rule-level model of the entry front end.
module tb_parking_entry_frontend;
    localparam int DEB = 4;
    localparam int TO  = 64;
`ifdef ENTRY_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clock_in = 1'b0;
    logic       rst_in = 1'b0;
    logic       front_raw = 1'b0;
    logic       back_raw = 1'b0;
    logic       key_enter = 1'b0;
    logic       clear_in = 1'b0;
    logic [1:0] digit_in = 2'b00;
    logic       Front_Sensor;
    logic       Back_Sensor;
    logic [1:0] pass_1;
    logic [1:0] pass_2;
    logic       pass_valid;
    logic [1:0] digit_cnt;

    int errors = 0;
    int checks = 0;

    parking_entry_frontend #(
        .DEB_CYCLES    (DEB),
        .CNT_W         (8),
        .ENTRY_TIMEOUT (TO)
    ) dut (
        .clock_in     (clock_in),
        .rst_in       (rst_in),
        .front_raw    (front_raw),
        .back_raw     (back_raw),
        .key_enter    (key_enter),
        .clear_in     (clear_in),
        .digit_in     (digit_in),
        .Front_Sensor (Front_Sensor),
        .Back_Sensor  (Back_Sensor),
        .pass_1       (pass_1),
        .pass_2       (pass_2),
        .pass_valid   (pass_valid),
        .digit_cnt    (digit_cnt)
    );

    always #5 clock_in = ~clock_in;

    // Model: each raw input is seen two samples late; a sensor output follows its
    // delayed input once they have disagreed for DEB samples in a row; the password
    // is a digit count plus two stored digits.
    bit         h_f[$], h_b[$], h_k[$], h_c[$];
    bit         m_front, m_back, m_back_old, m_key_old;
    int         run_f, run_b, m_idle, m_cnt;
    logic [1:0] m_d1, m_d2;

    task automatic model_reset();
        h_f.delete(); h_b.delete(); h_k.delete(); h_c.delete();
        repeat (2) begin
            h_f.push_back(1'b0); h_b.push_back(1'b0);
            h_k.push_back(1'b0); h_c.push_back(1'b0);
        end
        m_front = 0; m_back = 0; m_back_old = 0; m_key_old = 0;
        run_f = 0; run_b = 0; m_idle = 0; m_cnt = 0; m_d1 = 0; m_d2 = 0;
    endtask

    task automatic model_step(input bit f, input bit b, input bit k, input bit c,
                              input logic [1:0] dg);
        bit sf, sb, sk, sc, kevt, bevt;
        sf = h_f.pop_front(); h_f.push_back(f);
        sb = h_b.pop_front(); h_b.push_back(b);
        sk = h_k.pop_front(); h_k.push_back(k);
        sc = h_c.pop_front(); h_c.push_back(c);
        kevt = sk && !m_key_old;
        m_key_old = sk;
        bevt = m_back && !m_back_old;
        m_back_old = m_back;
        if (sf == m_front) run_f = 0;
        else begin run_f++; if (run_f == DEB) begin m_front = sf; run_f = 0; end end
        if (sb == m_back) run_b = 0;
        else begin run_b++; if (run_b == DEB) begin m_back = sb; run_b = 0; end end
        if (sc || bevt) begin
            m_cnt = 0; m_d1 = 0; m_d2 = 0;
        end else if (kevt) begin
            if (m_cnt == 0) begin m_d1 = dg; m_cnt = 1; m_idle = 0; end
            else if (m_cnt == 1) begin m_d2 = dg; m_cnt = 2; end
        end else if (m_cnt == 1 && TMO_EN) begin
            m_idle++;
            if (m_idle == TO) begin m_cnt = 0; m_d1 = 0; end
        end
    endtask

    // One clock: sample inputs, advance the model at the edge, settle 1 time unit.
    task automatic tick();
        bit f, b, k, c, r;
        logic [1:0] dg;
        f = front_raw; b = back_raw; k = key_enter; c = clear_in; dg = digit_in; r = rst_in;
        @(posedge clock_in);
        if (!r) model_reset();
        else model_step(f, b, k, c, dg);
        #1;
    endtask

    task automatic press(input logic [1:0] dg);
        digit_in = dg;
        key_enter = 1'b1;
        repeat (3) tick();
        key_enter = 1'b0;
        repeat (3) tick();
    endtask

    task automatic wipe();
        clear_in = 1'b1;
        repeat (3) tick();
        clear_in = 1'b0;
        repeat (3) tick();
    endtask

    task automatic test_reset();
        rst_in = 1'b0;
        repeat (2) tick();
        checks++;
        if ({Front_Sensor, Back_Sensor, pass_1, pass_2, pass_valid, digit_cnt} !== 9'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b expected 0",
                     {Front_Sensor, Back_Sensor, pass_1, pass_2, pass_valid, digit_cnt});
        end
        rst_in = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_glitch();
        front_raw = 1'b1;
        repeat (2) tick();
        front_raw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (Front_Sensor !== 1'b0) begin
                errors++;
                $display("FAIL glitch_front cyc%0d: got %b expected 0", i, Front_Sensor);
            end
        end
    endtask

    task automatic test_latency();
        front_raw = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (Front_Sensor !== (i >= 6)) begin
                errors++;
                $display("FAIL rise_latency cyc%0d: got %b expected %b", i, Front_Sensor, i >= 6);
            end
        end
        front_raw = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            tick();
            checks++;
            if (Front_Sensor !== (i < 6)) begin
                errors++;
                $display("FAIL fall_latency cyc%0d: got %b expected %b", i, Front_Sensor, i < 6);
            end
        end
    endtask

    task automatic test_password();
        press(2'b01);
        checks++;
        if ({digit_cnt, pass_valid, pass_1, pass_2} !== {2'd1, 1'b0, 2'b00, 2'b00}) begin
            errors++;
            $display("FAIL first_digit: got cnt=%0d v=%b p1=%b p2=%b expected cnt=1 v=0 p1=00 p2=00",
                     digit_cnt, pass_valid, pass_1, pass_2);
        end
        press(2'b10);
        checks++;
        if ({digit_cnt, pass_valid, pass_1, pass_2} !== {2'd2, 1'b1, 2'b01, 2'b10}) begin
            errors++;
            $display("FAIL two_digits: got cnt=%0d v=%b p1=%b p2=%b expected cnt=2 v=1 p1=01 p2=10",
                     digit_cnt, pass_valid, pass_1, pass_2);
        end
        press(2'b11);
        checks++;
        if ({digit_cnt, pass_valid, pass_1, pass_2} !== {2'd2, 1'b1, 2'b01, 2'b10}) begin
            errors++;
            $display("FAIL third_key_ignored: got cnt=%0d v=%b p1=%b p2=%b expected cnt=2 v=1 p1=01 p2=10",
                     digit_cnt, pass_valid, pass_1, pass_2);
        end
        wipe();
        checks++;
        if ({digit_cnt, pass_valid, pass_1, pass_2} !== 7'd0) begin
            errors++;
            $display("FAIL clear_full: got cnt=%0d v=%b p1=%b p2=%b expected all 0",
                     digit_cnt, pass_valid, pass_1, pass_2);
        end
    endtask

    task automatic test_clear_priority();
        press(2'b11);
        digit_in = 2'b10;
        key_enter = 1'b1;
        clear_in = 1'b1;
        repeat (3) tick();
        checks++;
        if ({digit_cnt, pass_valid, pass_1, pass_2} !== 7'd0) begin
            errors++;
            $display("FAIL clear_beats_key: got cnt=%0d v=%b p1=%b p2=%b expected all 0",
                     digit_cnt, pass_valid, pass_1, pass_2);
        end
        key_enter = 1'b0;
        clear_in = 1'b0;
        repeat (3) tick();
        checks++;
        if (digit_cnt !== 2'd0) begin
            errors++;
            $display("FAIL clear_settled: got cnt=%0d expected 0", digit_cnt);
        end
    endtask

    task automatic test_timeout();
        press(2'b01);
        // press() ends three cycles after the digit was captured.
        for (int el = 4; el <= 70; el++) begin
            tick();
            checks++;
            if (digit_cnt !== ((TMO_EN && el >= TO) ? 2'd0 : 2'd1)) begin
                errors++;
                $display("FAIL timeout el=%0d: got cnt=%0d expected %0d", el, digit_cnt,
                         (TMO_EN && el >= TO) ? 0 : 1);
            end
        end
        wipe();
    endtask

    task automatic test_back_clear();
        press(2'b01);
        press(2'b10);
        back_raw = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            tick();
            checks++;
            if ({Back_Sensor, pass_valid} !== {i >= 6, i < 7}) begin
                errors++;
                $display("FAIL back_sequence cyc%0d: got back=%b v=%b expected back=%b v=%b",
                         i, Back_Sensor, pass_valid, i >= 6, i < 7);
            end
        end
        checks++;
        if ({digit_cnt, pass_1, pass_2} !== 6'd0) begin
            errors++;
            $display("FAIL back_clears_regs: got cnt=%0d p1=%b p2=%b expected 0 00 00",
                     digit_cnt, pass_1, pass_2);
        end
        back_raw = 1'b0;
        repeat (8) tick();
    endtask

    task automatic test_async_reset();
        front_raw = 1'b1;
        repeat (8) tick();
        press(2'b11);
        #2;
        rst_in = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({Front_Sensor, Back_Sensor, pass_1, pass_2, pass_valid, digit_cnt} !== 9'd0) begin
            errors++;
            $display("FAIL async_reset: got %b expected 0",
                     {Front_Sensor, Back_Sensor, pass_1, pass_2, pass_valid, digit_cnt});
        end
        front_raw = 1'b0;
        tick();
        rst_in = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if ($urandom_range(5) == 0) front_raw = ~front_raw;
            if ($urandom_range(19) == 0) back_raw = ~back_raw;
            if ($urandom_range(3) == 0) key_enter = ~key_enter;
            if (clear_in) clear_in = ($urandom_range(1) == 0);
            else clear_in = ($urandom_range(49) == 0);
            if (!key_enter && $urandom_range(2) == 0) digit_in = 2'($urandom_range(3));
            tick();
            checks++;
            if ({Front_Sensor, Back_Sensor} !== {m_front, m_back}) begin
                errors++;
                $display("FAIL rand_sensors cyc%0d: got f=%b b=%b expected f=%b b=%b",
                         cyc, Front_Sensor, Back_Sensor, m_front, m_back);
            end
            checks++;
            if (digit_cnt !== 2'(m_cnt) || pass_valid !== (m_cnt == 2)) begin
                errors++;
                $display("FAIL rand_count cyc%0d: got cnt=%0d v=%b expected cnt=%0d v=%b",
                         cyc, digit_cnt, pass_valid, m_cnt, m_cnt == 2);
            end
            checks++;
            if (pass_1 !== ((m_cnt == 2) ? m_d1 : 2'b00) ||
                pass_2 !== ((m_cnt == 2) ? m_d2 : 2'b00)) begin
                errors++;
                $display("FAIL rand_pass cyc%0d: got p1=%b p2=%b expected p1=%b p2=%b", cyc,
                         pass_1, pass_2, (m_cnt == 2) ? m_d1 : 2'b00, (m_cnt == 2) ? m_d2 : 2'b00);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_glitch();
        test_latency();
        test_password();
        test_clear_priority();
        test_timeout();
        test_back_clear();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
